// File: rtl/pipelined_barrel_shifter.sv
// Pipelined N-bit barrel shifter (LSL/LSR/ASR/ROR) with ARM-style carry-out.
// One shift level per stage; a single global stall freezes every stage under backpressure.
module pipelined_barrel_shifter #(
    parameter int N   = 32,
    parameter int SHW = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           In_Valid,
    output logic           In_Ready,
    input  logic [N-1:0]   RN_In,
    input  logic [SHW-1:0] Sh,
    input  logic [1:0]     Mode,
    input  logic           Carry_In,
    output logic           Out_Valid,
    input  logic           Out_Ready,
    output logic [N-1:0]   Shift_Out,
    output logic           Carry_Out
);

    logic                 stall_s;

    logic [N-1:0]         src_data_s  [SHW];
    logic [SHW-1:0]       src_sh_s    [SHW];
    logic [1:0]           src_mode_s  [SHW];
    logic [SHW-1:0]       src_carry_s;
    logic [SHW-1:0]       src_valid_s;

    logic [N-1:0]         data_d [SHW];
    logic [N-1:0]         data_q [SHW];
    logic [SHW-1:0]       carry_d;
    logic [SHW-1:0]       carry_q;
    logic [SHW-1:0]       valid_d;
    logic [SHW-1:0]       valid_q;

    // The last stage no longer needs the shift amount or mode.
    logic [SHW-1:0]       sh_d   [SHW-1];
    logic [SHW-1:0]       sh_q   [SHW-1];
    logic [1:0]           mode_d [SHW-1];
    logic [1:0]           mode_q [SHW-1];

    assign stall_s   = valid_q[SHW-1] & ~Out_Ready;
    assign In_Ready  = ~stall_s;
    assign Out_Valid = valid_q[SHW-1];
    assign Shift_Out = data_q[SHW-1];
    assign Carry_Out = carry_q[SHW-1];

    // Select what feeds each level: the ports for level 0, the previous stage otherwise.
    always_comb begin
        src_data_s[0]  = RN_In;
        src_sh_s[0]    = Sh;
        src_mode_s[0]  = Mode;
        src_carry_s[0] = Carry_In;
        src_valid_s[0] = In_Valid;
        for (int k = 1; k < SHW; k++) begin
            src_data_s[k]  = data_q[k-1];
            src_sh_s[k]    = sh_q[k-1];
            src_mode_s[k]  = mode_q[k-1];
            src_carry_s[k] = carry_q[k-1];
            src_valid_s[k] = valid_q[k-1];
        end
    end

    // Level k shifts by 2^k; the carry becomes the last bit that this level pushed out,
    // which composes across levels into the bit last shifted out overall.
    always_comb begin
        int             amt;
        logic [SHW-1:0] lsl_idx;
        logic [SHW-1:0] rsh_idx;
        amt     = 0;
        lsl_idx = {SHW{1'b0}};
        rsh_idx = {SHW{1'b0}};
        for (int k = 0; k < SHW; k++) begin
            amt        = 32'sd1 << k;
            lsl_idx    = SHW'(N - amt);
            rsh_idx    = SHW'(amt - 1);
            data_d[k]  = data_q[k];
            carry_d[k] = carry_q[k];
            valid_d[k] = valid_q[k];
            if (!stall_s) begin
                valid_d[k] = src_valid_s[k];
                if (src_sh_s[k][k]) begin
                    case (src_mode_s[k])
                        2'b00: begin
                            data_d[k]  = src_data_s[k] << amt;
                            carry_d[k] = src_data_s[k][lsl_idx];
                        end
                        2'b01: begin
                            data_d[k]  = src_data_s[k] >> amt;
                            carry_d[k] = src_data_s[k][rsh_idx];
                        end
                        2'b10: begin
                            data_d[k]  = $signed(src_data_s[k]) >>> amt;
                            carry_d[k] = src_data_s[k][rsh_idx];
                        end
                        2'b11: begin
                            data_d[k]  = (src_data_s[k] >> amt) | (src_data_s[k] << (N - amt));
                            carry_d[k] = src_data_s[k][rsh_idx];
                        end
                        default: begin
                            data_d[k]  = src_data_s[k];
                            carry_d[k] = src_carry_s[k];
                        end
                    endcase
                end else begin
                    data_d[k]  = src_data_s[k];
                    carry_d[k] = src_carry_s[k];
                end
            end else begin
                data_d[k]  = data_q[k];
                carry_d[k] = carry_q[k];
                valid_d[k] = valid_q[k];
            end
        end
    end

    // Shift amount and mode ride along with their item, frozen on stall.
    always_comb begin
        for (int k = 0; k < SHW - 1; k++) begin
            if (stall_s) begin
                sh_d[k]   = sh_q[k];
                mode_d[k] = mode_q[k];
            end else begin
                sh_d[k]   = src_sh_s[k];
                mode_d[k] = src_mode_s[k];
            end
        end
    end

    // Stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SHW; k++) begin
                data_q[k] <= {N{1'b0}};
            end
            for (int k = 0; k < SHW - 1; k++) begin
                sh_q[k]   <= {SHW{1'b0}};
                mode_q[k] <= 2'b00;
            end
            carry_q <= {SHW{1'b0}};
            valid_q <= {SHW{1'b0}};
        end else begin
            for (int k = 0; k < SHW; k++) begin
                data_q[k] <= data_d[k];
            end
            for (int k = 0; k < SHW - 1; k++) begin
                sh_q[k]   <= sh_d[k];
                mode_q[k] <= mode_d[k];
            end
            carry_q <= carry_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed self-checking bench for pipelined_barrel_shifter (N=32, SHW=5).
module tb_pipelined_barrel_shifter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        In_Valid;
    logic        In_Ready;
    logic [31:0] RN_In;
    logic [4:0]  Sh;
    logic [1:0]  Mode;
    logic        Carry_In;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [31:0] Shift_Out;
    logic        Carry_Out;

    int n_checks = 0;
    int n_err    = 0;

    pipelined_barrel_shifter #(.N(32), .SHW(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .RN_In     (RN_In),
        .Sh        (Sh),
        .Mode      (Mode),
        .Carry_In  (Carry_In),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Shift_Out (Shift_Out),
        .Carry_Out (Carry_Out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Send one item, then count cycles until its result appears (accept edge -> valid).
    task automatic run_vec(input string tag, input logic [31:0] rn, input logic [4:0] sh,
                           input logic [1:0] md, input logic cin,
                           input logic [31:0] exp_o, input logic exp_c);
        int cyc;
        @(negedge clk);
        In_Valid = 1'b1; RN_In = rn; Sh = sh; Mode = md; Carry_In = cin;
        @(negedge clk);
        In_Valid = 1'b0; RN_In = ~rn; Sh = ~sh; Mode = ~md; Carry_In = ~cin;
        cyc = 1;
        while (!Out_Valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_lat"},   64'(cyc), 64'd5);
        chk({tag, "_valid"}, 64'(Out_Valid), 64'd1);
        chk({tag, "_data"},  64'(Shift_Out), 64'(exp_o));
        chk({tag, "_carry"}, 64'(Carry_Out), 64'(exp_c));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] t_rn  [12] = '{32'h0000_00F1, 32'h8000_0003, 32'h8000_0003, 32'h1234_5678,
                                   32'h1234_5678, 32'h8000_0000, 32'h0000_0003, 32'h8000_0000,
                                   32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 32'h0000_F000};
        logic [4:0]  t_sh  [12] = '{5'd4, 5'd1, 5'd1, 5'd8, 5'd0, 5'd1, 5'd31, 5'd31,
                                   5'd31, 5'd1, 5'd4, 5'd0};
        logic [1:0]  t_md  [12] = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b11, 2'b00, 2'b00, 2'b10,
                                   2'b01, 2'b11, 2'b10, 2'b01};
        logic        t_ci  [12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                   1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] t_eo  [12] = '{32'h0000_0F10, 32'hC000_0001, 32'h4000_0001, 32'h7812_3456,
                                   32'h1234_5678, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF,
                                   32'h0000_0001, 32'h8000_0000, 32'h07FF_FFFF, 32'h0000_F000};
        logic        t_ec  [12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                                   1'b0, 1'b1, 1'b1, 1'b0};
        int          tx;
        int          rx;
        int          hold;
        logic        seen_first;
        logic [31:0] held_val;
        logic [31:0] m_rn;
        logic [31:0] m_out;
        logic        m_c;
        int          m_sh;

        rst_n = 1'b0; In_Valid = 1'b0; RN_In = 32'h0; Sh = 5'd0; Mode = 2'b00;
        Carry_In = 1'b0; Out_Ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(Out_Valid), 64'd0);
        chk("rst_data",  64'(Shift_Out), 64'd0);
        chk("rst_carry", 64'(Carry_Out), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(In_Ready), 64'd1);

        // Directed single-item vectors across all modes and boundaries
        for (int i = 0; i < 12; i++) begin
            run_vec($sformatf("vec%0d", i), t_rn[i], t_sh[i], t_md[i], t_ci[i], t_eo[i], t_ec[i]);
        end

        // Back-to-back streaming: 16 inputs, outputs 1<<i from cycle 5 with no gaps
        for (int c = 0; c < 23; c++) begin
            @(negedge clk);
            if (c >= 5 && c < 21) begin
                chk($sformatf("stream%0d_valid", c - 5), 64'(Out_Valid), 64'd1);
                chk($sformatf("stream%0d_data", c - 5), 64'(Shift_Out), 64'd1 << (c - 5));
                chk($sformatf("stream%0d_carry", c - 5), 64'(Carry_Out), 64'd0);
            end else begin
                chk($sformatf("stream_idle%0d", c), 64'(Out_Valid), 64'd0);
            end
            if (c < 16) begin
                In_Valid = 1'b1; RN_In = 32'h1; Sh = 5'(c); Mode = 2'b00; Carry_In = 1'b0;
            end else begin
                In_Valid = 1'b0;
            end
        end

        // Backpressure: hold Out_Ready low for 3 cycles after the first result
        tx = 0; rx = 0; hold = 0; seen_first = 1'b0; held_val = 32'h0;
        for (int c = 0; c < 60 && rx < 8; c++) begin
            @(negedge clk);
            if (!seen_first && Out_Valid) begin
                seen_first = 1'b1;
                hold = 3;
            end
            Out_Ready = (hold == 0);
            #1;
            if (hold > 0) begin
                chk("bp_in_ready_low", 64'(In_Ready), 64'd0);
                if (hold < 3) begin
                    chk("bp_hold_valid", 64'(Out_Valid), 64'd1);
                    chk("bp_hold_data",  64'(Shift_Out), 64'(held_val));
                end
                held_val = Shift_Out;
                hold--;
            end
            if (Out_Valid && Out_Ready) begin
                m_rn  = 32'h8000_0000 | 32'(rx);
                m_sh  = rx;
                m_out = m_rn << m_sh;
                m_c   = (m_sh == 0) ? 1'b1 : m_rn[32 - m_sh];
                chk($sformatf("bp%0d_data", rx), 64'(Shift_Out), 64'(m_out));
                chk($sformatf("bp%0d_carry", rx), 64'(Carry_Out), 64'(m_c));
                rx++;
            end
            if (tx < 8) begin
                In_Valid = 1'b1; RN_In = 32'h8000_0000 | 32'(tx); Sh = 5'(tx);
                Mode = 2'b00; Carry_In = 1'b1;
                if (In_Ready) tx++;
            end else begin
                In_Valid = 1'b0;
            end
        end
        chk("bp_delivered", 64'(rx), 64'd8);
        chk("bp_hold_seen", 64'(seen_first), 64'd1);
        Out_Ready = 1'b1;
        In_Valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("bp_no_dup", 64'(Out_Valid), 64'd0);
        end

        // Reset mid-stream with items in flight and a stalled result at the output
        Out_Ready = 1'b0;
        for (int c = 0; c < 12 && !Out_Valid; c++) begin
            @(negedge clk);
            if (!Out_Valid) begin
                In_Valid = 1'b1; RN_In = 32'h0000_0100 + 32'(c); Sh = 5'd1; Mode = 2'b01;
                Carry_In = 1'b0;
            end
        end
        chk("mid_pre_valid", 64'(Out_Valid), 64'd1);
        #2;
        rst_n = 1'b0;
        In_Valid = 1'b0;
        #1;
        chk("mid_rst_valid",    64'(Out_Valid), 64'd0);
        chk("mid_rst_data",     64'(Shift_Out), 64'd0);
        chk("mid_rst_carry",    64'(Carry_Out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        Out_Ready = 1'b1;
        #1;
        chk("mid_rst_in_ready", 64'(In_Ready), 64'd1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("mid_no_stale", 64'(Out_Valid), 64'd0);
        end
        run_vec("post_rst", 32'hF000_0000, 5'd4, 2'b10, 1'b1, 32'hFF00_0000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
